ahb_lite_master: RTL and testbench
==================================

# ahb_lite_master

Single-channel AHB-lite bus master: the initiator-side counterpart of the team's AHB-lite SRAM slave. It accepts a command (start address, direction, size, beat count) on a valid/ready interface and issues a pipelined incrementing sequence of AHB-lite transfers. Write data is pulled beat by beat from a data port, and read data is pushed out with a valid strobe. It sits between a DMA/CPU-side requester and the AHB-lite interconnect.

## Interface
- AW, 32: address width (ahbl_addr, cmd_addr).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clken  input  1  clock enable; all registers update only when high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted on clk edge when cmd_valid & cmd_ready & clken.
- cmd_addr  input  AW  start byte address; low bits below the size are forced to 0.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_size  input  3  0 byte, 1 halfword, 2 word; values >2 are treated as 2.
- cmd_len  input  8  beats minus 1 (1..256 beats).
- wr_data  input  32  write data for the current write data phase; must be stable while the phase is stalled.
- wr_ready  output  1  current write beat consumed this cycle; requester presents the next beat after this edge.
- rd_data  output  32  equals ahbl_rdata.
- rd_valid  output  1  rd_data is a completed read beat.
- done  output  1  one-cycle pulse: final data phase of a command has completed.
- ahbl_addr  output  AW  AHB address.
- ahbl_trans  output  2  00 IDLE, 10 NONSEQ, 11 SEQ (BUSY never issued).
- ahbl_write  output  1  transfer direction.
- ahbl_size  output  3  transfer size.
- ahbl_wdata  output  32  write data = wr_data during a write data phase, else 0.
- ahbl_rdata  input  32  read data.
- ahbl_ready  input  1  slave ready; ends the current data phase and advances the address phase.

## Operation
- Two-stage pipeline: address-phase registers (addr, trans, write, size, beats remaining) and data-phase registers (dp_active, dp_write, dp_last).
- States: IDLE (trans=00, no burst), ADDR (issuing beats). cmd_ready = (state==IDLE), independent of the data phase, so a new command may be accepted while the previous command's last data phase is still stalled.
- Acceptance in IDLE: load the address registers and go to ADDR. The first beat is NONSEQ on the next cycle.
- In ADDR, on an edge with clken & ahbl_ready:
  - the current beat moves to the data phase;
  - addr += 1<<size;
  - remaining -= 1;
  - the next trans is SEQ.
  - After the last beat, go to IDLE with trans=00.
- 1KB rule: if the incremented address has addr[9:0]==0, that beat is issued as NONSEQ instead of SEQ. Address arithmetic is modulo 2^AW.
- While ahbl_ready=0, the address and control outputs hold unchanged.
- Data phase:
  - wr_ready = clken & ahbl_ready & dp_active & dp_write.
  - rd_valid = clken & ahbl_ready & dp_active & ~dp_write.
  - done = clken & ahbl_ready & dp_active & dp_last.
  - dp_active is cleared after an edge with ahbl_ready=1 if no beat was transferred in.
- Mixed direction: a read command may follow a write command and vice versa. The data-phase direction is taken from dp_write, not from the current command.
- clken low: no state changes. wr_ready, rd_valid and done are forced to 0; AHB outputs hold.

## Timing
- Reset (asynchronous, immediate): ahbl_trans=00, ahbl_addr=0, ahbl_write=0, ahbl_size=0, ahbl_wdata=0, cmd_ready=1, wr_ready=0, rd_valid=0, done=0, dp_active=0.
- Reset mid-burst: the burst is abandoned with no done pulse; the bus goes IDLE at once.
- Latency:
  - command accepted at edge N → NONSEQ visible in cycle N+1;
  - beat k completes its data phase at the earliest in cycle N+2+k.
- Throughput with zero wait states: one beat per cycle.
- Gap between commands: at least one IDLE address cycle, because the last beat's address cycle has cmd_ready=0.
- Single-beat command (cmd_len=0): NONSEQ for one cycle, then IDLE; done in the following cycle.

## Test plan
- Reset state: assert reset mid-burst → trans=00 and cmd_ready=1 in the same cycle, no done; after release the bus stays IDLE.
- Word write burst, addr 0x100, len 3, ready always 1 → trans 10,11,11,11 at addr 0x100/104/108/10C; wr_ready high 4 consecutive cycles; done on the 4th.
- Byte read burst, addr 0x3, len 2, ready low 2 cycles during the second beat → addresses 0x3/4/5 with the address held during the stall; rd_valid is exactly 3 pulses carrying the matching ahbl_rdata.
- 1KB crossing: word write, addr 0x3F8, len 3 → trans 10,11,10,11 at 0x3F8/3FC/400/404.
- Back-to-back commands: write len 0 then read len 1 presented continuously → one IDLE cycle between them; the read data phases are flagged rd_valid, not wr_ready.
- clken toggling at 50% during a 4-beat read → same address/trans sequence, with rd_valid only on clken=1 edges; 4 rd_valid pulses and 1 done total.

Source files
------------

// File: rtl/ahb_lite_master.sv
// Single-channel AHB-lite bus master.
// Command-driven incrementing bursts with a two-stage address/data pipeline.
module ahb_lite_master #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clken,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_write,
  input  logic [2:0]    cmd_size,
  input  logic [7:0]    cmd_len,
  input  logic [31:0]   wr_data,
  output logic          wr_ready,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          done,
  output logic [AW-1:0] ahbl_addr,
  output logic [1:0]    ahbl_trans,
  output logic          ahbl_write,
  output logic [2:0]    ahbl_size,
  output logic [31:0]   ahbl_wdata,
  input  logic [31:0]   ahbl_rdata,
  input  logic          ahbl_ready
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_ADDR = 1'b1;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic          state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    trans_q, trans_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;
  logic [7:0]    rem_q, rem_d;
  logic          dp_active_q, dp_active_d;
  logic          dp_write_q, dp_write_d;
  logic          dp_last_q, dp_last_d;

  logic [2:0]    size_c;
  logic [AW-1:0] amask;
  logic [AW-1:0] addr_inc;
  logic          adv;
  logic          dp_adv;

  assign size_c   = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
  assign amask    = ~((AW'(1) << size_c) - AW'(1));
  assign addr_inc = addr_q + (AW'(1) << size_q);
  assign adv      = clken & ahbl_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    trans_d     = trans_q;
    write_d     = write_q;
    size_d      = size_q;
    rem_d       = rem_q;
    dp_active_d = dp_active_q;
    dp_write_d  = dp_write_q;
    dp_last_d   = dp_last_q;
    // A completed data phase empties the slot unless a beat moves in.
    if (adv) begin
      dp_active_d = 1'b0;
    end
    if (state_q == S_IDLE) begin
      if (clken & cmd_valid) begin
        state_d = S_ADDR;
        addr_d  = cmd_addr & amask;
        trans_d = T_NONSEQ;
        write_d = cmd_write;
        size_d  = size_c;
        rem_d   = cmd_len;
      end
    end else if (adv) begin
      dp_active_d = 1'b1;
      dp_write_d  = write_q;
      dp_last_d   = (rem_q == 8'd0);
      if (rem_q == 8'd0) begin
        state_d = S_IDLE;
        trans_d = T_IDLE;
      end else begin
        addr_d  = addr_inc;
        rem_d   = rem_q - 8'd1;
        // Crossing a 1KB boundary restarts the burst.
        trans_d = (addr_inc[9:0] == 10'd0) ? T_NONSEQ : T_SEQ;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      trans_q     <= T_IDLE;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      rem_q       <= 8'd0;
      dp_active_q <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_last_q   <= 1'b0;
    end else if (clken) begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      trans_q     <= trans_d;
      write_q     <= write_d;
      size_q      <= size_d;
      rem_q       <= rem_d;
      dp_active_q <= dp_active_d;
      dp_write_q  <= dp_write_d;
      dp_last_q   <= dp_last_d;
    end
  end

  assign dp_adv     = adv & dp_active_q;
  assign cmd_ready  = (state_q == S_IDLE);
  assign wr_ready   = dp_adv & dp_write_q;
  assign rd_valid   = dp_adv & ~dp_write_q;
  assign done       = dp_adv & dp_last_q;
  assign rd_data    = ahbl_rdata;
  assign ahbl_addr  = addr_q;
  assign ahbl_trans = trans_q;
  assign ahbl_write = write_q;
  assign ahbl_size  = size_q;
  assign ahbl_wdata = (dp_active_q & dp_write_q) ? wr_data : 32'd0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master.
// Per-cycle expectations are hand-derived from the bus protocol.
module tb_ahb_lite_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        clken;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic [31:0] ahbl_addr;
  logic [1:0]  ahbl_trans;
  logic        ahbl_write;
  logic [2:0]  ahbl_size;
  logic [31:0] ahbl_wdata;
  logic [31:0] ahbl_rdata;
  logic        ahbl_ready;

  always #5 clk = ~clk;

  ahb_lite_master #(.AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clken      (clken),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_size   (cmd_size),
    .cmd_len    (cmd_len),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .done       (done),
    .ahbl_addr  (ahbl_addr),
    .ahbl_trans (ahbl_trans),
    .ahbl_write (ahbl_write),
    .ahbl_size  (ahbl_size),
    .ahbl_wdata (ahbl_wdata),
    .ahbl_rdata (ahbl_rdata),
    .ahbl_ready (ahbl_ready)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   wcnt = 0;
  int   rcnt = 0;
  int   rv_tot = 0;
  int   dn_tot = 0;
  logic wr_seen = 1'b0;
  logic rd_seen = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at posedge+1, settle, sample at negedge.
  task automatic cyc(input logic rdy, input logic ce);
    @(posedge clk);
    #1;
    if (wr_seen) wcnt++;
    if (rd_seen) rcnt++;
    ahbl_ready = rdy;
    clken      = ce;
    wr_data    = 32'hA000_0000 + wcnt;
    ahbl_rdata = 32'hD000_0000 + rcnt;
    #4;
    wr_seen = wr_ready;
    rd_seen = rd_valid;
    rv_tot += int'(rd_valid);
    dn_tot += int'(done);
  endtask

  task automatic expc(input string tag,
                      input logic [1:0] t,
                      input logic [31:0] a,
                      input logic wrr,
                      input logic rdv,
                      input logic dn,
                      input logic [31:0] wd,
                      input logic [31:0] rd);
    check({tag, ".trans"}, 32'(ahbl_trans), 32'(t));
    if (t != 2'b00) check({tag, ".addr"}, ahbl_addr, a);
    check({tag, ".wr_ready"}, 32'(wr_ready), 32'(wrr));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(rdv));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".wdata"}, ahbl_wdata, wd);
    if (rdv) check({tag, ".rd_data"}, rd_data, rd);
  endtask

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [2:0] s, input logic [7:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_len   = l;
  endtask

  task automatic clr();
    wcnt = 0;
    rcnt = 0;
    wr_seen = 1'b0;
    rd_seen = 1'b0;
    rv_tot = 0;
    dn_tot = 0;
  endtask

  initial begin
    reset      = 1'b1;
    clken      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr   = 32'd0;
    cmd_write  = 1'b0;
    cmd_size   = 3'd0;
    cmd_len    = 8'd0;
    wr_data    = 32'd0;
    ahbl_rdata = 32'd0;
    ahbl_ready = 1'b1;
    #2;
    check("rst.trans", 32'(ahbl_trans), 32'd0);
    check("rst.addr", ahbl_addr, 32'd0);
    check("rst.write", 32'(ahbl_write), 32'd0);
    check("rst.size", 32'(ahbl_size), 32'd0);
    check("rst.wdata", ahbl_wdata, 32'd0);
    check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst.wr_ready", 32'(wr_ready), 32'd0);
    check("rst.rd_valid", 32'(rd_valid), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Word write burst, zero wait states
    clr();
    cyc(1, 1);
    send(1'b1, 32'h100, 3'd2, 8'd3);
    check("wr.cmd_ready", 32'(cmd_ready), 32'd1);
    cyc(1, 1);
    cmd_valid = 1'b0;
    expc("wr.c1", 2'b10, 32'h100, 0, 0, 0, 32'd0, 32'd0);
    check("wr.size", 32'(ahbl_size), 32'd2);
    check("wr.write", 32'(ahbl_write), 32'd1);
    check("wr.busy", 32'(cmd_ready), 32'd0);
    cyc(1, 1);
    expc("wr.c2", 2'b11, 32'h104, 1, 0, 0, 32'hA000_0000, 32'd0);
    cyc(1, 1);
    expc("wr.c3", 2'b11, 32'h108, 1, 0, 0, 32'hA000_0001, 32'd0);
    cyc(1, 1);
    expc("wr.c4", 2'b11, 32'h10C, 1, 0, 0, 32'hA000_0002, 32'd0);
    cyc(1, 1);
    expc("wr.c5", 2'b00, 32'h0, 1, 0, 1, 32'hA000_0003, 32'd0);
    cyc(1, 1);
    expc("wr.c6", 2'b00, 32'h0, 0, 0, 0, 32'd0, 32'd0);

    // Byte read burst with two wait states on the second address
    clr();
    cyc(1, 1);
    send(1'b0, 32'h3, 3'd0, 8'd2);
    cyc(1, 1);
    cmd_valid = 1'b0;
    expc("rd.c1", 2'b10, 32'h3, 0, 0, 0, 32'd0, 32'd0);
    check("rd.size", 32'(ahbl_size), 32'd0);
    cyc(0, 1);
    expc("rd.c2", 2'b11, 32'h4, 0, 0, 0, 32'd0, 32'd0);
    cyc(0, 1);
    expc("rd.c3", 2'b11, 32'h4, 0, 0, 0, 32'd0, 32'd0);
    cyc(1, 1);
    expc("rd.c4", 2'b11, 32'h4, 0, 1, 0, 32'd0, 32'hD000_0000);
    cyc(1, 1);
    expc("rd.c5", 2'b11, 32'h5, 0, 1, 0, 32'd0, 32'hD000_0001);
    cyc(1, 1);
    expc("rd.c6", 2'b00, 32'h0, 0, 1, 1, 32'd0, 32'hD000_0002);
    cyc(1, 1);
    expc("rd.c7", 2'b00, 32'h0, 0, 0, 0, 32'd0, 32'd0);
    check("rd.pulses", 32'(rv_tot), 32'd3);

    // 1KB crossing; unaligned start is forced to a word address
    clr();
    cyc(1, 1);
    send(1'b1, 32'h3FB, 3'd2, 8'd3);
    cyc(1, 1);
    cmd_valid = 1'b0;
    expc("kb.c1", 2'b10, 32'h3F8, 0, 0, 0, 32'd0, 32'd0);
    cyc(1, 1);
    expc("kb.c2", 2'b11, 32'h3FC, 1, 0, 0, 32'hA000_0000, 32'd0);
    cyc(1, 1);
    expc("kb.c3", 2'b10, 32'h400, 1, 0, 0, 32'hA000_0001, 32'd0);
    cyc(1, 1);
    expc("kb.c4", 2'b11, 32'h404, 1, 0, 0, 32'hA000_0002, 32'd0);
    cyc(1, 1);
    expc("kb.c5", 2'b00, 32'h0, 1, 0, 1, 32'hA000_0003, 32'd0);
    cyc(1, 1);
    expc("kb.c6", 2'b00, 32'h0, 0, 0, 0, 32'd0, 32'd0);

    // Back-to-back: single write then two-beat read
    clr();
    cyc(1, 1);
    send(1'b1, 32'h20, 3'd2, 8'd0);
    cyc(1, 1);
    expc("bb.c1", 2'b10, 32'h20, 0, 0, 0, 32'd0, 32'd0);
    check("bb.c1.cmd_ready", 32'(cmd_ready), 32'd0);
    send(1'b0, 32'h40, 3'd2, 8'd1);
    cyc(1, 1);
    expc("bb.c2", 2'b00, 32'h0, 1, 0, 1, 32'hA000_0000, 32'd0);
    check("bb.c2.cmd_ready", 32'(cmd_ready), 32'd1);
    cyc(1, 1);
    cmd_valid = 1'b0;
    expc("bb.c3", 2'b10, 32'h40, 0, 0, 0, 32'd0, 32'd0);
    check("bb.c3.write", 32'(ahbl_write), 32'd0);
    cyc(1, 1);
    expc("bb.c4", 2'b11, 32'h44, 0, 1, 0, 32'd0, 32'hD000_0000);
    cyc(1, 1);
    expc("bb.c5", 2'b00, 32'h0, 0, 1, 1, 32'd0, 32'hD000_0001);
    cyc(1, 1);
    expc("bb.c6", 2'b00, 32'h0, 0, 0, 0, 32'd0, 32'd0);

    // clken toggling at 50% during a 4-beat word read
    clr();
    cyc(1, 1);
    send(1'b0, 32'h200, 3'd2, 8'd3);
    cyc(1, 0);
    cmd_valid = 1'b0;
    expc("ce.c1", 2'b10, 32'h200, 0, 0, 0, 32'd0, 32'd0);
    cyc(1, 1);
    expc("ce.c2", 2'b10, 32'h200, 0, 0, 0, 32'd0, 32'd0);
    cyc(1, 0);
    expc("ce.c3", 2'b11, 32'h204, 0, 0, 0, 32'd0, 32'd0);
    cyc(1, 1);
    expc("ce.c4", 2'b11, 32'h204, 0, 1, 0, 32'd0, 32'hD000_0000);
    cyc(1, 0);
    expc("ce.c5", 2'b11, 32'h208, 0, 0, 0, 32'd0, 32'd0);
    cyc(1, 1);
    expc("ce.c6", 2'b11, 32'h208, 0, 1, 0, 32'd0, 32'hD000_0001);
    cyc(1, 0);
    expc("ce.c7", 2'b11, 32'h20C, 0, 0, 0, 32'd0, 32'd0);
    cyc(1, 1);
    expc("ce.c8", 2'b11, 32'h20C, 0, 1, 0, 32'd0, 32'hD000_0002);
    cyc(1, 0);
    expc("ce.c9", 2'b00, 32'h0, 0, 0, 0, 32'd0, 32'd0);
    cyc(1, 1);
    expc("ce.c10", 2'b00, 32'h0, 0, 1, 1, 32'd0, 32'hD000_0003);
    cyc(1, 0);
    cyc(1, 1);
    expc("ce.c12", 2'b00, 32'h0, 0, 0, 0, 32'd0, 32'd0);
    check("ce.rd_pulses", 32'(rv_tot), 32'd4);
    check("ce.done_pulses", 32'(dn_tot), 32'd1);

    // Reset asserted in the middle of a long read burst
    clr();
    cyc(1, 1);
    send(1'b0, 32'h80, 3'd2, 8'd7);
    cyc(1, 1);
    cmd_valid = 1'b0;
    cyc(1, 1);
    expc("mr.c2", 2'b11, 32'h84, 0, 1, 0, 32'd0, 32'hD000_0000);
    reset = 1'b1;
    #1;
    check("mr.trans", 32'(ahbl_trans), 32'd0);
    check("mr.addr", ahbl_addr, 32'd0);
    check("mr.cmd_ready", 32'(cmd_ready), 32'd1);
    check("mr.rd_valid", 32'(rd_valid), 32'd0);
    check("mr.done", 32'(done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    dn_tot = 0;
    rd_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1);
      expc("mr.post", 2'b00, 32'h0, 0, 0, 0, 32'd0, 32'd0);
    end
    check("mr.no_done", 32'(dn_tot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
